fan_pwm_ctrl: RTL and testbench

FAN_PWM_CTRL -- requirements
Module: fan_pwm_ctrl

---
 rtl/fan_pkg.sv | 14 +
 rtl/fan_tach_meter.sv | 81 ++++++++
 rtl/fan_pwm_ctrl.sv | 104 ++++++++++
 tb/tb_fan_pwm_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared state type and default sizing for the fan PWM controller
package fan_pkg;

   localparam int unsigned DEF_PWM_W        = 16;
   localparam int unsigned DEF_TACH_W       = 16;
   localparam int unsigned DEF_KICK_PERIODS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KICK = 2'd1,
      RUN  = 2'd2
   } fan_state_t;

endpackage

// File: rtl/fan_tach_meter.sv
// rtl/fan_tach_meter.sv - tach synchroniser, rising-edge counter over a gate window, stall flag
module fan_tach_meter
   import fan_pkg::*;
#(
   parameter int unsigned TACH_W = DEF_TACH_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [31:0]       gate_i,
   input  logic              tach_i,
   input  logic              run_i,
   input  logic              clr_i,
   output logic [TACH_W-1:0] count_o,
   output logic              valid_o,
   output logic              stall_o
);

   logic              sync1_q;
   logic              sync2_q;
   logic              prev_q;
   logic [31:0]       gate_q;
   logic [31:0]       gate_sh_q;
   logic [TACH_W-1:0] edges_q;
   logic [TACH_W-1:0] edges_d;
   logic [TACH_W-1:0] count_q;
   logic              valid_q;
   logic              stall_q;
   logic              rise;
   logic              term;

   assign rise = sync2_q & ~prev_q;
   // Window length is latched at each window start so a mid-window gate write cannot truncate it.
   assign term = (gate_q == gate_sh_q);

   always_comb begin
      edges_d = edges_q;
      if (rise && (edges_q != '1)) begin
         edges_d = edges_q + TACH_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
         gate_q    <= '0;
         gate_sh_q <= '0;
         edges_q   <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         stall_q   <= 1'b0;
      end else begin
         sync1_q <= tach_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         valid_q <= term;
         if (term) begin
            gate_q    <= '0;
            gate_sh_q <= gate_i;
            count_q   <= edges_d;
            edges_q   <= '0;
         end else begin
            gate_q  <= gate_q + 32'd1;
            edges_q <= edges_d;
         end
         if (clr_i) begin
            stall_q <= 1'b0;
         end else if (term && (edges_d == '0) && run_i) begin
            stall_q <= 1'b1;
         end else if (term && (edges_d != '0)) begin
            stall_q <= 1'b0;
         end
      end
   end

   assign count_o = count_q;
   assign valid_o = valid_q;
   assign stall_o = stall_q;

endmodule

// File: rtl/fan_pwm_ctrl.sv
// rtl/fan_pwm_ctrl.sv - fan PWM generator with kick-start sequence and tachometer measurement
module fan_pwm_ctrl
   import fan_pkg::*;
#(
   parameter int unsigned PWM_W        = DEF_PWM_W,
   parameter int unsigned TACH_W       = DEF_TACH_W,
   parameter int unsigned KICK_PERIODS = DEF_KICK_PERIODS
) (
   input  logic              axi_aclk,
   input  logic              axi_aresetn,
   input  logic              cfg_enable,
   input  logic [15:0]       cfg_prescale,
   input  logic [PWM_W-1:0]  cfg_period,
   input  logic [PWM_W-1:0]  cfg_duty,
   input  logic [31:0]       cfg_gate,
   input  logic              tach_in,
   output logic              fan_pwm,
   output logic [TACH_W-1:0] tach_count,
   output logic              tach_valid,
   output logic              stall
);

   localparam int unsigned KICK_W = $clog2(KICK_PERIODS + 2);
   localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'((KICK_PERIODS == 0) ? 0 : KICK_PERIODS - 1);

   fan_state_t        state_q;
   logic [15:0]       presc_q;
   logic [PWM_W-1:0]  cnt_q;
   logic [PWM_W-1:0]  per_sh_q;
   logic [PWM_W-1:0]  duty_sh_q;
   logic [KICK_W-1:0] kick_q;
   logic              pwm_q;
   logic              tick;
   logic              wrap;
   logic              meter_run;
   logic              meter_clr;

   assign tick = (presc_q >= cfg_prescale);
   assign wrap = tick && (cnt_q >= per_sh_q);

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         cnt_q     <= '0;
         kick_q    <= '0;
         per_sh_q  <= '0;
         duty_sh_q <= '0;
         pwm_q     <= 1'b0;
      end else if (!cfg_enable) begin
         state_q <= IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         kick_q  <= '0;
         pwm_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         state_q   <= KICK;
         presc_q   <= '0;
         cnt_q     <= '0;
         kick_q    <= '0;
         per_sh_q  <= cfg_period;
         duty_sh_q <= cfg_duty;
         pwm_q     <= 1'b0;
      end else begin
         // Compare runs on the shadows so a duty write only lands on a period boundary.
         pwm_q   <= (state_q == KICK) || (cnt_q < duty_sh_q);
         presc_q <= tick ? '0 : presc_q + 16'd1;
         if (wrap) begin
            cnt_q     <= '0;
            per_sh_q  <= cfg_period;
            duty_sh_q <= cfg_duty;
            if (state_q == KICK) begin
               if (kick_q == KICK_LAST) begin
                  state_q <= RUN;
                  kick_q  <= '0;
               end else begin
                  kick_q <= kick_q + KICK_W'(1);
               end
            end
         end else if (tick) begin
            cnt_q <= cnt_q + PWM_W'(1);
         end
      end
   end

   assign fan_pwm   = pwm_q;
   assign meter_run = (state_q == RUN);
   assign meter_clr = ~cfg_enable;

   fan_tach_meter #(
      .TACH_W (TACH_W)
   ) u_tach (
      .clk_i   (axi_aclk),
      .rst_ni  (axi_aresetn),
      .gate_i  (cfg_gate),
      .tach_i  (tach_in),
      .run_i   (meter_run),
      .clr_i   (meter_clr),
      .count_o (tach_count),
      .valid_o (tach_valid),
      .stall_o (stall)
   );

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// tb/tb_fan_pwm_ctrl.sv - randomized self-checking bench for fan_pwm_ctrl against a period-level model
`timescale 1ns/100ps
module tb_fan_pwm_ctrl;
   import fan_pkg::*;

   localparam int     PWM_W    = 16;
   localparam int     TACH_W   = 16;
   localparam int     KICK     = 2;
   localparam longint TACH_MAX = (longint'(1) << TACH_W) - 1;

   logic              axi_aclk     = 1'b0;
   logic              axi_aresetn  = 1'b0;
   logic              cfg_enable   = 1'b0;
   logic [15:0]       cfg_prescale = '0;
   logic [PWM_W-1:0]  cfg_period   = '0;
   logic [PWM_W-1:0]  cfg_duty     = '0;
   logic [31:0]       cfg_gate     = 32'd99;
   logic              tach_in      = 1'b0;
   logic              fan_pwm;
   logic [TACH_W-1:0] tach_count;
   logic              tach_valid;
   logic              stall;

   int n_checks  = 0;
   int n_errors  = 0;
   int tach_mode = 0;
   bit chk_en    = 1'b0;

   // model state: PWM tracked as clock positions inside whole periods
   bit     m_on       = 1'b0;
   int     m_kick_left = 0;
   longint m_pos = 0, m_len = 1, m_high = 0;
   longint m_gpos = 0, m_glen = 1, m_edges = 0;
   bit [3:1] m_hist = '0;
   bit     e_pwm = 1'b0, e_valid = 1'b0, e_stall = 1'b0;
   longint e_count = 0;

   fan_pwm_ctrl #(
      .PWM_W        (PWM_W),
      .TACH_W       (TACH_W),
      .KICK_PERIODS (KICK)
   ) dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .cfg_enable   (cfg_enable),
      .cfg_prescale (cfg_prescale),
      .cfg_period   (cfg_period),
      .cfg_duty     (cfg_duty),
      .cfg_gate     (cfg_gate),
      .tach_in      (tach_in),
      .fan_pwm      (fan_pwm),
      .tach_count   (tach_count),
      .tach_valid   (tach_valid),
      .stall        (stall)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic load_period();
      m_len  = (longint'(cfg_period) + 1) * (longint'(cfg_prescale) + 1);
      m_high = longint'(cfg_duty) * (longint'(cfg_prescale) + 1);
   endtask

   task automatic model_step();
      bit     rise;
      bit     term;
      bit     in_run;
      longint c;
      if (!axi_aresetn) begin
         m_on = 1'b0; m_kick_left = 0; m_pos = 0;
         m_gpos = 0; m_glen = 1; m_edges = 0; m_hist = '0;
         e_pwm = 1'b0; e_valid = 1'b0; e_stall = 1'b0; e_count = 0;
         return;
      end
      in_run = m_on && (m_kick_left == 0);
      rise   = m_hist[2] && !m_hist[3];
      m_hist = {m_hist[2], m_hist[1], tach_in};
      c = m_edges + longint'(rise);
      if (c > TACH_MAX) c = TACH_MAX;
      term = (m_gpos == m_glen - 1);
      if (term) begin
         e_count = c; e_valid = 1'b1; m_edges = 0; m_gpos = 0;
         m_glen  = longint'(cfg_gate) + 1;
      end else begin
         e_valid = 1'b0; m_edges = c; m_gpos++;
      end
      if (!cfg_enable) e_stall = 1'b0;
      else if (term && c == 0 && in_run) e_stall = 1'b1;
      else if (term && c != 0) e_stall = 1'b0;

      if (!cfg_enable) begin
         m_on = 1'b0; e_pwm = 1'b0;
      end else if (!m_on) begin
         m_on = 1'b1; m_kick_left = KICK; m_pos = 0; load_period(); e_pwm = 1'b0;
      end else begin
         e_pwm = (m_kick_left > 0) || (m_pos < m_high);
         m_pos++;
         if (m_pos == m_len) begin
            m_pos = 0;
            if (m_kick_left > 0) m_kick_left--;
            load_period();
         end
      end
   endtask

   initial forever begin
      @(posedge axi_aclk or negedge axi_aresetn);
      model_step();
   end

   initial forever begin
      @(negedge axi_aclk);
      if (chk_en) begin
         check("fan_pwm", fan_pwm, e_pwm);
         check("tach_valid", tach_valid, e_valid);
         check("tach_count", tach_count, e_count);
         check("stall", stall, e_stall);
      end
   end

   // tach edges always land at x.3 ns, never on a clock edge
   initial begin
      #3.3;
      forever begin
         case (tach_mode)
            0: begin tach_in = 1'b0; #1; end
            1: begin tach_in = 1'b1; #200; tach_in = 1'b0; #200; end
            default: begin tach_in = ~tach_in; #($urandom_range(1, 40)); end
         endcase
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge axi_aclk);
         n++;
      end while (!tach_valid && n < 3000);
      if (!tach_valid) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_valid: no tach_valid within %0d clocks", n);
      end
   endtask

   initial begin
      int  n;
      bit  exp;
      repeat (3) @(negedge axi_aclk);
      check("rst_fan_pwm", fan_pwm, 0);
      check("rst_tach_count", tach_count, 0);
      check("rst_tach_valid", tach_valid, 0);
      check("rst_stall", stall, 0);
      check("rst_state", int'(dut.state_q), int'(IDLE));
      axi_aresetn = 1'b1;
      chk_en      = 1'b1;

      // kick then 3/7 pattern, duty 3->7 written mid-period
      cfg_prescale = 16'd0; cfg_period = 16'd9; cfg_duty = 16'd3;
      cfg_enable   = 1'b1;
      for (int i = 0; i < 51; i++) begin
         @(negedge axi_aclk);
         if (i == 0) exp = 1'b0;
         else if (i <= 20) exp = 1'b1;
         else if (i < 31) exp = ((i - 21) % 10) < 3;
         else exp = ((i - 31) % 10) < 7;
         check("pattern", fan_pwm, exp);
         if (i == 25) cfg_duty = 16'd7;
      end

      cfg_duty = 16'd0;
      repeat (12) @(negedge axi_aclk);
      for (int i = 0; i < 20; i++) begin
         @(negedge axi_aclk);
         check("duty0_low", fan_pwm, 0);
      end
      cfg_duty = 16'd12;
      repeat (12) @(negedge axi_aclk);
      for (int i = 0; i < 20; i++) begin
         @(negedge axi_aclk);
         check("duty12_high", fan_pwm, 1);
      end

      // 25 pulses per 1000-clock window
      cfg_duty  = 16'd5;
      cfg_gate  = 32'd999;
      tach_mode = 1;
      wait_valid(n);
      wait_valid(n);
      for (int k = 0; k < 2; k++) begin
         wait_valid(n);
         check("gate_interval", n, 1000);
         check("tach25_count", tach_count, 25);
         check("tach25_stall", stall, 0);
      end

      // stall on silent tach, then recovery
      tach_mode = 0;
      wait_valid(n);
      wait_valid(n);
      check("silent_count", tach_count, 0);
      check("silent_stall", stall, 1);
      tach_mode = 1;
      wait_valid(n);
      wait_valid(n);
      check("resume_count", tach_count, 25);
      check("resume_stall", stall, 0);
      tach_mode = 0;
      wait_valid(n);
      wait_valid(n);
      check("silent2_stall", stall, 1);

      // enable dropped while driving high in RUN
      n = 0;
      while (!fan_pwm && n < 20) begin
         @(negedge axi_aclk);
         n++;
      end
      check("run_high_before_drop", fan_pwm, 1);
      cfg_enable = 1'b0;
      @(posedge axi_aclk);
      #1;
      check("drop_fan_pwm", fan_pwm, 0);
      check("drop_state", int'(dut.state_q), int'(IDLE));
      check("drop_stall", stall, 0);

      // async reset mid-KICK
      tach_mode = 2;
      @(negedge axi_aclk);
      cfg_enable = 1'b1;
      repeat (6) @(negedge axi_aclk);
      check("kick_high", fan_pwm, 1);
      @(posedge axi_aclk);
      #3;
      axi_aresetn = 1'b0;
      #1;
      check("areset_fan_pwm", fan_pwm, 0);
      check("areset_tach_count", tach_count, 0);
      check("areset_tach_valid", tach_valid, 0);
      check("areset_stall", stall, 0);
      check("areset_state", int'(dut.state_q), int'(IDLE));
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;

      // random sessions against the model
      for (int s = 0; s < 6; s++) begin
         cfg_enable = 1'b0;
         repeat (3) @(negedge axi_aclk);
         cfg_prescale = 16'($urandom_range(0, 3));
         cfg_period   = 16'($urandom_range(0, 12));
         cfg_duty     = 16'($urandom_range(0, 15));
         cfg_gate     = 32'($urandom_range(5, 150));
         cfg_enable   = 1'b1;
         for (int c = 0; c < 400; c++) begin
            @(negedge axi_aclk);
            if ($urandom_range(0, 30) == 0) cfg_duty = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 30) == 0) cfg_period = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 60) == 0) cfg_gate = 32'($urandom_range(5, 150));
            if (s == 3 && c == 100) begin
               @(posedge axi_aclk);
               #2;
               axi_aresetn = 1'b0;
               @(negedge axi_aclk);
               axi_aresetn = 1'b1;
            end
         end
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
